ysyx_041514_execute_mdu: RTL
============================

Name: ysyx_041514_execute_mdu

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed-width mul/div path that currently stalls the pipeline through the ALU result buffer. It takes RV64M/RV32M-style requests over a valid/ready handshake, computes over multiple cycles with a radix-2 shift-add or restoring-divide datapath, and holds the result until EX/MEM accepts it. Word-mode (…W) operations and pipeline flush are supported natively.

Parameters:
XLEN, 64, operand and result width (32 or 64).
WORD_LEN, 32, operand width for word-mode ops; result sign-extended from WORD_LEN to XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid_i  input  1  request valid.
req_ready_o  output  1  unit can accept a request.
op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
word_i  input  1  word-mode op (MULW/DIVW/DIVUW/REMW/REMUW); ignored for op 1–3.
a_i  input  XLEN  rs1 operand.
b_i  input  XLEN  rs2 operand.
flush_i  input  1  kill the in-flight op (branch/trap redirect).
resp_valid_o  output  1  result valid.
resp_ready_i  input  1  consumer accepts result.
resp_data_o  output  XLEN  result.
busy_o  output  1  state != IDLE; drives the EX stall request.

Behaviour:
- FSM: IDLE, CALC, FIX, DONE. Reset: state IDLE, all registers 0, resp_valid_o=0, resp_data_o=0, busy_o=0. req_ready_o=1 once reset is released.
- req_ready_o = (state==IDLE) & ~flush_i. Accept on req_valid_i & req_ready_o. Operands, op and word are latched; inputs are don't-care afterwards.
- Operand width L = WORD_LEN if word_i (mul/div ops only), else XLEN. Low L bits are used; signed ops take magnitudes and record result sign.
- Special cases, resolved at accept, go IDLE→DONE (resp_valid_o at T+1 after the accept edge T):
  - Divisor 0: quotient = all ones (L bits); remainder = dividend.
  - Signed overflow (-2^(L-1) / -1): quotient = dividend; remainder = 0.
- Normal path:
  - CALC runs exactly L cycles with a counter, one bit per cycle.
  - FIX (1 cycle) applies sign negation, selects low/high product or quotient/remainder, and sign-extends word results from bit WORD_LEN-1.
  - DONE is entered at T+L+2, where resp_valid_o goes high.
- Multiply keeps a 2L-bit product. MUL returns bits [L-1:0]; MULH/MULHSU/MULHU return bits [2L-1:L] with signed/signed, signed/unsigned and unsigned/unsigned interpretation.
- Remainder sign follows the dividend; quotient sign is the XOR of operand signs.
- DONE: resp_valid_o=1 and resp_data_o held stable until resp_valid_o & resp_ready_i, then IDLE next cycle. No new request is accepted in the same cycle as the response handshake.
- flush_i in any state: next state IDLE, resp_valid_o=0 next cycle, result discarded. flush_i and req_valid_i in the same cycle: flush wins, no accept.
- Async reset mid-operation returns to reset values immediately; no response is produced.
- busy_o = (state != IDLE). The result is never presented combinationally in the accept cycle.

Test Plan:
- MUL, word=0, a=7, b=0xFFFFFFFFFFFFFFFD (-3), accept at T -> resp_valid_o rises at T+66, resp_data_o=0xFFFFFFFFFFFFFFEB; busy_o high T+1..T+66.
- MULHU a=0xFFFFFFFFFFFFFFFF, b=2 -> 0x0000000000000001. MULH same operands -> 0xFFFFFFFFFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFFFFFFFFFD. REM same operands -> 0xFFFFFFFFFFFFFFFF. DIVW a=0x00000000_FFFFFFF9, b=2 -> 0xFFFFFFFFFFFFFFFD with resp at T+34.
- Special cases, each resp at T+1:
  - DIVU b=0 -> 0xFFFFFFFFFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIVW a=0x80000000, b=0xFFFFFFFF -> 0xFFFFFFFF80000000.
  - REMW same operands -> 0.
- Backpressure: hold resp_ready_i low 5 cycles in DONE -> resp_valid_o and resp_data_o stable, req_ready_o=0. Then assert resp_ready_i -> req_ready_o=1 next cycle and a back-to-back request is accepted.
- Kill paths:
  - flush_i at CALC cycle 10 -> resp_valid_o never asserts, req_ready_o=1 next cycle.
  - rst low mid-CALC -> immediate reset values.
  - flush_i with req_valid_i in IDLE -> no accept.

Source files
------------

// File: rtl/ysyx_041514_execute_mdu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_041514_execute_mdu
// Brief   : Iterative radix-2 multiply / restoring-divide unit for the EX stage
// Revision: 1.0
// ============================================================================
module ysyx_041514_execute_mdu #(
    parameter int XLEN     = 64,
    parameter int WORD_LEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONES_W = (XLEN'(1) << WORD_LEN) - XLEN'(1);
    localparam logic [XLEN-1:0] MIN_W  = XLEN'(1) << (WORD_LEN - 1);
    localparam logic [XLEN-1:0] MIN_X  = XLEN'(1) << (XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic w);
        return w ? (x & ONES_W) : x;
    endfunction

    function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] x, input logic w);
        logic [XLEN-1:0] y;
        y = x;
        if (w) y = x[WORD_LEN-1] ? (x | ~ONES_W) : (x & ONES_W);
        return y;
    endfunction

    // Request decode: operand width, signedness, magnitudes and early-out cases
    logic            is_div, word_eff, a_sgn_op, b_sgn_op, a_neg, b_neg;
    logic            b_zero, ovf, special, accept;
    logic [XLEN-1:0] a_l, b_l, a_mag, b_mag, special_result;

    always_comb begin
        is_div   = op_i[2];
        word_eff = word_i & (is_div | (op_i == 3'd0));
        a_l      = fit(a_i, word_eff);
        b_l      = fit(b_i, word_eff);
        a_sgn_op = is_div ? ~op_i[0] : ((op_i == 3'd1) || (op_i == 3'd2));
        b_sgn_op = is_div ? ~op_i[0] : (op_i == 3'd1);
        a_neg    = a_sgn_op & (word_eff ? a_i[WORD_LEN-1] : a_i[XLEN-1]);
        b_neg    = b_sgn_op & (word_eff ? b_i[WORD_LEN-1] : b_i[XLEN-1]);
        a_mag    = a_neg ? fit(-a_l, word_eff) : a_l;
        b_mag    = b_neg ? fit(-b_l, word_eff) : b_l;
        b_zero   = (b_l == '0);
        ovf      = is_div & ~op_i[0] & (a_l == (word_eff ? MIN_W : MIN_X))
                 & (b_l == fit({XLEN{1'b1}}, word_eff));
        special  = is_div & (b_zero | ovf);
        if (b_zero) special_result = op_i[1] ? sext(a_l, word_eff) : {XLEN{1'b1}};
        else        special_result = op_i[1] ? '0 : sext(a_l, word_eff);
    end

    assign req_ready_o  = (state == IDLE) & ~flush_i;
    assign accept       = req_valid_i & req_ready_o;
    assign resp_valid_o = (state == DONE);
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    logic [CNT_W-1:0] cnt;

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid_i) state_next = special ? DONE : CALC;
                CALC: if (cnt == '0) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: if (resp_ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // acc: product (mul) or {remainder, quotient} (div); opa: shifting multiplicand/dividend
    logic [2:0]        op_q;
    logic              word_q, a_neg_q, b_neg_q;
    logic [2*XLEN-1:0] acc, opa;
    logic [XLEN-1:0]   opb, result;

    logic            div_bit, div_ok;
    logic [XLEN:0]   div_shift, div_trial;

    always_comb begin
        div_bit   = word_q ? opa[WORD_LEN-1] : opa[XLEN-1];
        div_shift = {acc[2*XLEN-1:XLEN], div_bit};
        div_trial = div_shift - {1'b0, opb};
        div_ok    = ~div_trial[XLEN];
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_raw, rem_raw, div_sel, fix_result;

    always_comb begin
        prod    = (a_neg_q ^ b_neg_q) ? -acc : acc;
        quo_raw = acc[XLEN-1:0];
        rem_raw = acc[2*XLEN-1:XLEN];
        div_sel = op_q[1] ? (a_neg_q ? -rem_raw : rem_raw)
                          : ((a_neg_q ^ b_neg_q) ? -quo_raw : quo_raw);
        if (op_q[2])            fix_result = sext(div_sel, word_q);
        else if (op_q == 3'd0)  fix_result = sext(prod[XLEN-1:0], word_q);
        else                    fix_result = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            word_q  <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            result  <= '0;
        end else if (accept) begin
            op_q    <= op_i;
            word_q  <= word_eff;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            cnt     <= word_eff ? CNT_W'(WORD_LEN - 1) : CNT_W'(XLEN - 1);
            acc     <= '0;
            opa     <= {{XLEN{1'b0}}, a_mag};
            opb     <= b_mag;
            if (special) result <= special_result;
        end else if (!flush_i) begin
            if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                opa <= opa << 1;
                if (op_q[2]) begin
                    acc[2*XLEN-1:XLEN] <= div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
                    acc[XLEN-1:0]      <= {acc[XLEN-2:0], div_ok};
                end else begin
                    if (opb[0]) acc <= acc + opa;
                    opb <= opb >> 1;
                end
            end else if (state == FIX) begin
                result <= fix_result;
            end
        end
    end

    assign resp_data_o = result;

endmodule
`default_nettype wire
